// File: rtl/hifi4_aquila_e2_prod_pif_sram_slave.sv
// PIF SRAM slave: single-beat read/write requests into a 64-bit wide
// byte-writable memory window, with responses returned in acceptance
// order through a 2-entry response FIFO (one-cycle response latency).
module hifi4_aquila_e2_prod_pif_sram_slave #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADRS  = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        Reset_N,
   input  logic        POReqValid,
   output logic        PIReqRdy,
   input  logic [7:0]  POReqCntl,
   input  logic [31:0] POReqAdrs,
   input  logic [63:0] POReqData,
   input  logic [7:0]  POReqDataBE,
   input  logic [5:0]  POReqId,
   input  logic [1:0]  POReqPriority,
   input  logic [11:0] POReqAttribute,
   output logic        PIRespValid,
   input  logic        PORespRdy,
   output logic [7:0]  PIRespCntl,
   output logic [63:0] PIRespData,
   output logic [5:0]  PIRespId,
   output logic [1:0]  PIRespPriority
);

   localparam int          DEPTH        = 1 << DEPTH_LOG2;
   localparam logic [32:0] WINDOW_BYTES = 33'd8 << DEPTH_LOG2;

   localparam logic [7:0] CNTL_READ     = 8'h00;
   localparam logic [7:0] CNTL_WRITE    = 8'h80;
   localparam logic [7:0] RESP_OK       = 8'h01;
   localparam logic [7:0] RESP_ADRS_ERR = 8'h03;
   localparam logic [7:0] RESP_TYPE_ERR = 8'h05;

   // Flow-control state
   logic       reqRdyReg;
   logic [1:0] countReg;
   logic [1:0] countNext;
   logic       wrPtrReg;
   logic       rdPtrReg;
   logic       accept;
   logic       pop;

   // Request decode
   logic [31:0]           reqOffset;
   logic                  inWindow;
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic                  isRead;
   logic                  isWrite;
   logic                  memWe;
   logic [7:0]            respCntlNext;
   logic [63:0]           respDataNext;
   logic [63:0]           memRdWord;

   // Response FIFO storage (no reset: entries are only visible while counted)
   logic [7:0]  fifoCntl [2];
   logic [63:0] fifoData [2];
   logic [5:0]  fifoId   [2];
   logic [1:0]  fifoPri  [2];

   // Attribute and the sub-word address bits carry no meaning here.
   logic unusedBits;
   assign unusedBits = ^{POReqAttribute, reqOffset[2:0]};

   assign accept = POReqValid & reqRdyReg;
   assign pop    = PIRespValid & PORespRdy;

   // The offset is taken modulo 2^32, so addresses below the base wrap to a
   // large offset and fall out of the window naturally.
   assign reqOffset = POReqAdrs - BASE_ADRS;
   assign inWindow  = ({1'b0, reqOffset} < WINDOW_BYTES);
   assign wordIdx   = reqOffset[DEPTH_LOG2+2:3];
   assign isRead    = (POReqCntl == CNTL_READ);
   assign isWrite   = (POReqCntl == CNTL_WRITE);

   // Classify the request; type errors take precedence over address errors,
   // and only an OK write may touch memory.
   always_comb begin
      respCntlNext = RESP_OK;
      respDataNext = 64'h0;
      memWe        = 1'b0;
      if (!isRead && !isWrite) begin
         respCntlNext = RESP_TYPE_ERR;
      end else if (!inWindow) begin
         respCntlNext = RESP_ADRS_ERR;
      end else if (isWrite) begin
         memWe = accept;
      end else begin
         respDataNext = memRdWord;
      end
   end

   // One memory array per byte lane so each lane has a single write enable.
   for (genvar gi = 0; gi < 8; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH];

      // Byte-lane write on acceptance of an in-window write
      always_ff @(posedge CLK) begin
         if (memWe && POReqDataBE[gi]) begin
            laneMem[wordIdx] <= POReqData[gi*8 +: 8];
         end
      end

      assign memRdWord[gi*8 +: 8] = laneMem[wordIdx];
   end

   // Capture the response into the FIFO tail; the read word is sampled at
   // the same edge as any write, so it reflects pre-write contents.
   always_ff @(posedge CLK) begin
      if (accept) begin
         fifoCntl[wrPtrReg] <= respCntlNext;
         fifoData[wrPtrReg] <= respDataNext;
         fifoId[wrPtrReg]   <= POReqId;
         fifoPri[wrPtrReg]  <= POReqPriority;
      end
   end

   // Occupancy after this cycle's push and pop
   always_comb begin
      countNext = countReg;
      case ({accept, pop})
         2'b10:   countNext = countReg + 2'd1;
         2'b01:   countNext = countReg - 2'd1;
         default: countNext = countReg;
      endcase
   end

   // FIFO pointers, count and the registered request-ready flag
   always_ff @(posedge CLK or negedge Reset_N) begin
      if (!Reset_N) begin
         countReg  <= 2'd0;
         wrPtrReg  <= 1'b0;
         rdPtrReg  <= 1'b0;
         reqRdyReg <= 1'b0;
      end else begin
         countReg  <= countNext;
         reqRdyReg <= (countNext <= 2'd1);
         if (accept) begin
            wrPtrReg <= ~wrPtrReg;
         end
         if (pop) begin
            rdPtrReg <= ~rdPtrReg;
         end
      end
   end

   // Outputs are gated by occupancy so reset clears them asynchronously and
   // a stalled head entry stays stable until popped.
   assign PIReqRdy       = reqRdyReg;
   assign PIRespValid    = (countReg != 2'd0);
   assign PIRespCntl     = PIRespValid ? fifoCntl[rdPtrReg] : 8'h0;
   assign PIRespData     = PIRespValid ? fifoData[rdPtrReg] : 64'h0;
   assign PIRespId       = PIRespValid ? fifoId[rdPtrReg]   : 6'h0;
   assign PIRespPriority = PIRespValid ? fifoPri[rdPtrReg]  : 2'h0;

endmodule

// File: tb/tb_hifi4_aquila_e2_prod_pif_sram_slave.sv
// Directed bench for the PIF SRAM slave: a scoreboard queue receives the
// expected response when a request is accepted, and a monitor pops and
// compares each response as the master takes it.
module tb_hifi4_aquila_e2_prod_pif_sram_slave;

   localparam int          DL2  = 10;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] WIN  = 32'd8 << DL2;

   typedef struct packed {
      logic [7:0]  cntl;
      logic [63:0] data;
      logic [5:0]  id;
      logic [1:0]  pri;
   } resp_t;

   logic        CLK;
   logic        Reset_N;
   logic        POReqValid;
   logic        PIReqRdy;
   logic [7:0]  POReqCntl;
   logic [31:0] POReqAdrs;
   logic [63:0] POReqData;
   logic [7:0]  POReqDataBE;
   logic [5:0]  POReqId;
   logic [1:0]  POReqPriority;
   logic [11:0] POReqAttribute;
   logic        PIRespValid;
   logic        PORespRdy;
   logic [7:0]  PIRespCntl;
   logic [63:0] PIRespData;
   logic [5:0]  PIRespId;
   logic [1:0]  PIRespPriority;

   hifi4_aquila_e2_prod_pif_sram_slave #(
      .DEPTH_LOG2 (DL2),
      .BASE_ADRS  (BASE)
   ) dut (
      .CLK            (CLK),
      .Reset_N        (Reset_N),
      .POReqValid     (POReqValid),
      .PIReqRdy       (PIReqRdy),
      .POReqCntl      (POReqCntl),
      .POReqAdrs      (POReqAdrs),
      .POReqData      (POReqData),
      .POReqDataBE    (POReqDataBE),
      .POReqId        (POReqId),
      .POReqPriority  (POReqPriority),
      .POReqAttribute (POReqAttribute),
      .PIRespValid    (PIRespValid),
      .PORespRdy      (PORespRdy),
      .PIRespCntl     (PIRespCntl),
      .PIRespData     (PIRespData),
      .PIRespId       (PIRespId),
      .PIRespPriority (PIRespPriority)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checkCount = 0;
   int failCount  = 0;

   resp_t       respQ [$];
   logic [63:0] model [int unsigned];

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request and hold it until accepted; the expected response is
   // queued at the edge that accepts it.
   task automatic send(input logic [7:0] cntl, input logic [31:0] adrs,
                       input logic [63:0] data, input logic [7:0] be,
                       input logic [5:0] id, input logic [1:0] pri,
                       output int waits);
      logic [31:0] off;
      int unsigned idx;
      logic [63:0] w;
      resp_t       e;
      logic        accepted;
      off    = adrs - BASE;
      idx    = off >> 3;
      e.id   = id;
      e.pri  = pri;
      e.data = 64'h0;
      if (cntl != 8'h00 && cntl != 8'h80) begin
         e.cntl = 8'h05;
      end else if (off >= WIN) begin
         e.cntl = 8'h03;
      end else if (cntl == 8'h80) begin
         e.cntl = 8'h01;
         w = model.exists(idx) ? model[idx] : 64'hx;
         for (int b = 0; b < 8; b++) begin
            if (be[b]) w[b*8 +: 8] = data[b*8 +: 8];
         end
         model[idx] = w;
      end else begin
         e.cntl = 8'h01;
         e.data = model.exists(idx) ? model[idx] : 64'hx;
      end
      POReqValid     = 1'b1;
      POReqCntl      = cntl;
      POReqAdrs      = adrs;
      POReqData      = data;
      POReqDataBE    = be;
      POReqId        = id;
      POReqPriority  = pri;
      POReqAttribute = 12'($urandom);
      waits    = 0;
      accepted = 1'b0;
      while (!accepted && waits < 50) begin
         @(negedge CLK);
         if (PIReqRdy) begin
            respQ.push_back(e);
            accepted = 1'b1;
         end else begin
            waits++;
         end
         @(posedge CLK);
         #1;
      end
      POReqValid = 1'b0;
      $display("req  id=%0d cntl=%h adrs=%h data=%h be=%h waits=%0d", id, cntl, adrs, data, be, waits);
      chk($sformatf("accepted_id%0d", id), 96'(accepted), 96'(1'b1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (respQ.size() != 0 && n < 50) begin
         @(posedge CLK);
         n++;
      end
      #1;
      chk("drain_empty", 96'(respQ.size()), 96'(0));
   endtask

   // Response monitor: compares popped responses and checks stall stability
   initial begin
      logic        prevStall;
      logic [80:0] prevOut;
      resp_t       exp;
      prevStall = 1'b0;
      prevOut   = '0;
      forever begin
         @(negedge CLK);
         if (!Reset_N) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall) begin
               chk("stall_hold", 96'({PIRespValid, PIRespCntl, PIRespData, PIRespId, PIRespPriority}), 96'(prevOut));
            end
            if (PIRespValid && PORespRdy) begin
               if (respQ.size() == 0) begin
                  chk("unexpected_resp_valid", 96'(PIRespValid), 96'(1'b0));
               end else begin
                  exp = respQ.pop_front();
                  $display("resp id=%0d pri=%0d cntl=%h data=%h", PIRespId, PIRespPriority, PIRespCntl, PIRespData);
                  chk($sformatf("resp_id%0d", exp.id),
                      96'({PIRespCntl, PIRespData, PIRespId, PIRespPriority}), 96'(exp));
               end
            end
            prevStall = PIRespValid && !PORespRdy;
            prevOut   = {PIRespValid, PIRespCntl, PIRespData, PIRespId, PIRespPriority};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int waits;
      Reset_N        = 1'b0;
      POReqValid     = 1'b0;
      POReqCntl      = 8'h0;
      POReqAdrs      = 32'h0;
      POReqData      = 64'h0;
      POReqDataBE    = 8'h0;
      POReqId        = 6'h0;
      POReqPriority  = 2'h0;
      POReqAttribute = 12'h0;
      PORespRdy      = 1'b1;

      // Reset state
      #2;
      chk("reset_outputs", 96'({PIRespValid, PIReqRdy, PIRespCntl, PIRespData, PIRespId, PIRespPriority}), 96'(0));
      repeat (3) @(posedge CLK);
      #3 Reset_N = 1'b1;
      @(negedge CLK);
      chk("rdy_before_first_edge", 96'(PIReqRdy), 96'(1'b0));
      @(posedge CLK);
      #1;
      chk("rdy_after_first_edge", 96'(PIReqRdy), 96'(1'b1));

      // Full write, latency, read back
      send(8'h80, BASE + 32'h10, 64'h1122334455667788, 8'hFF, 6'd5, 2'd1, waits);
      @(negedge CLK);
      chk("write_resp_latency", 96'(PIRespValid), 96'(1'b1));
      @(posedge CLK);
      #1;
      send(8'h00, BASE + 32'h10, 64'h0, 8'hFF, 6'd6, 2'd2, waits);

      // Partial write, read back
      send(8'h80, BASE + 32'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 6'd7, 2'd3, waits);
      send(8'h00, BASE + 32'h10, 64'h0, 8'hFF, 6'd8, 2'd0, waits);

      // Address and type errors leave memory untouched
      send(8'h00, BASE + WIN, 64'h0, 8'hFF, 6'd9, 2'd1, waits);
      send(8'h00, BASE - 32'd8, 64'h0, 8'hFF, 6'd10, 2'd2, waits);
      send(8'h10, BASE + 32'h10, 64'h0, 8'hFF, 6'd11, 2'd3, waits);
      send(8'h81, BASE + 32'h10, 64'hDEADBEEF_DEADBEEF, 8'hFF, 6'd12, 2'd0, waits);
      send(8'h80, BASE + WIN + 32'h10, 64'hFEEDFACE_FEEDFACE, 8'hFF, 6'd13, 2'd1, waits);
      send(8'h00, BASE + 32'h10, 64'h0, 8'hFF, 6'd14, 2'd2, waits);

      // Last word of the window, low address bits ignored
      send(8'h80, BASE + WIN - 32'd8, 64'h0123456789ABCDEF, 8'hFF, 6'd15, 2'd3, waits);
      send(8'h80, BASE + WIN - 32'd5, 64'h0, 8'h5A, 6'd16, 2'd0, waits);
      send(8'h00, BASE + WIN - 32'd1, 64'h0, 8'hFF, 6'd17, 2'd1, waits);
      drain();

      // Backpressure: two accepted, third held until a pop
      PORespRdy = 1'b0;
      send(8'h00, BASE + 32'h10, 64'h0, 8'hFF, 6'd20, 2'd1, waits);
      chk("bp_first_waits", 96'(waits), 96'(0));
      send(8'h80, BASE + 32'h18, 64'h5555666677778888, 8'hFF, 6'd21, 2'd2, waits);
      chk("bp_second_waits", 96'(waits), 96'(0));
      POReqValid = 1'b1;
      POReqCntl  = 8'h00;
      POReqAdrs  = BASE + 32'h18;
      POReqId    = 6'd22;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("bp_full_rdy", 96'(PIReqRdy), 96'(1'b0));
         chk("bp_head", 96'({PIRespValid, PIRespId}), 96'({1'b1, 6'd20}));
         @(posedge CLK);
         #1;
      end
      PORespRdy = 1'b1;
      send(8'h00, BASE + 32'h18, 64'h0, 8'hFF, 6'd22, 2'd3, waits);
      chk("bp_third_waits", 96'(waits), 96'(1));
      drain();

      // Continuous stream: one accept per cycle
      for (int i = 0; i < 6; i++) begin
         send((i % 2 == 0) ? 8'h80 : 8'h00, BASE + 32'h40 + 32'(8 * (i / 2)),
              64'h0101010101010101 * 64'(i + 1), 8'hFF, 6'(30 + i), 2'(i), waits);
         chk($sformatf("stream_waits_%0d", i), 96'(waits), 96'(0));
      end
      drain();

      // Reset with two responses queued
      PORespRdy = 1'b0;
      send(8'h00, BASE + 32'h10, 64'h0, 8'hFF, 6'd40, 2'd1, waits);
      send(8'h00, BASE + 32'h18, 64'h0, 8'hFF, 6'd41, 2'd2, waits);
      @(posedge CLK);
      #3 Reset_N = 1'b0;
      respQ.delete();
      #1;
      chk("midreset_outputs", 96'({PIRespValid, PIReqRdy, PIRespCntl, PIRespData, PIRespId, PIRespPriority}), 96'(0));
      PORespRdy = 1'b1;
      @(negedge CLK);
      @(posedge CLK);
      #3 Reset_N = 1'b1;
      @(negedge CLK);
      chk("midreset_rdy_before_edge", 96'(PIReqRdy), 96'(1'b0));
      @(posedge CLK);
      #1;
      chk("midreset_rdy_after_edge", 96'(PIReqRdy), 96'(1'b1));
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("no_stale_resp", 96'(PIRespValid), 96'(1'b0));
      end
      @(posedge CLK);
      #1;
      // Memory survives reset
      send(8'h00, BASE + 32'h10, 64'h0, 8'hFF, 6'd42, 2'd3, waits);
      drain();

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule

// File: doc/hifi4_aquila_e2_prod_pif_sram_slave.md
HIFI4_AQUILA_E2_PROD_PIF_SRAM_SLAVE -- requirements
Module: hifi4_aquila_e2_prod_pif_sram_slave

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH_LOG2  10  log2 of memory depth in 64-bit words.
  BASE_ADRS  32'h0000_0000  byte base address of the memory window.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  CLK  in  1  sole clock; all state updates on rising edge.
  Reset_N  in  1  asynchronous active-low reset.
  POReqValid  in  1  request valid.
  PIReqRdy  out  1  slave can accept a request this cycle.
  POReqCntl  in  8  request control.
  POReqAdrs  in  32  byte address.
  POReqData  in  64  write data.
  POReqDataBE  in  8  byte enables.
  POReqId  in  6  transaction id.
  POReqPriority  in  2  priority.
  POReqAttribute  in  12  attribute, ignored.
  PIRespValid  out  1  response valid.
  PORespRdy  in  1  master accepts response.
  PIRespCntl  out  8  response control.
  PIRespData  out  64  read data.
  PIRespId  out  6  echoed id.
  PIRespPriority  out  2  echoed priority.
REQ-003 There SHALL be one clock, CLK; reset SHALL be asynchronous and active-low, Reset_N.

Function
REQ-004 A request SHALL be accepted in a cycle where POReqValid and PIReqRdy are both 1.
REQ-005 Request decode: POReqCntl 8'h00 = single read, 8'h80 = single write; any other value = unsupported.
REQ-006 In-window: (POReqAdrs - BASE_ADRS) < 8*2^DEPTH_LOG2; word index = offset[DEPTH_LOG2+2:3]; address bits [2:0] ignored.
REQ-007 Accepted in-window write SHALL update only the bytes whose POReqDataBE bit is 1, in the acceptance cycle.
REQ-008 Accepted in-window read SHALL return the word as it stood before any write accepted in the same cycle (only one request per cycle, so no conflict exists).
REQ-009 Every accepted request SHALL produce exactly one response carrying its POReqId and POReqPriority.
REQ-010 PIRespCntl: 8'h01 = OK, last; 8'h03 = address error, last; 8'h05 = unsupported-type error, last.
REQ-011 Error responses SHALL carry PIRespData = 64'h0 and SHALL leave memory unchanged.
REQ-012 Write and error responses SHALL carry PIRespData = 64'h0; OK read responses carry the read word.
REQ-013 Responses SHALL pass through a 2-entry FIFO; the earliest response is in the cycle after acceptance (latency 1).
REQ-014 Responses SHALL be returned strictly in acceptance order.
REQ-015 A response SHALL be popped when PIRespValid and PORespRdy are both 1.
REQ-016 While PIRespValid=1 and PORespRdy=0, all response outputs SHALL be held stable.
REQ-017 PIReqRdy SHALL be registered and equal 1 iff the FIFO holds at most one entry after this cycle's push/pop, i.e. 1 when empty.
REQ-018 PIReqRdy with 1 entry: accept is allowed; with 2 entries: accept is allowed only after a pop.
REQ-019 Simultaneous push and pop at 2 entries SHALL NOT be possible, since PIReqRdy=0 at full.
REQ-020 A simultaneous push and pop at 1 entry SHALL keep the count at 1.
REQ-021 FIFO pointers SHALL be 1 bit and wrap modulo 2.
REQ-022 PIRespValid SHALL be 1 iff the FIFO count is nonzero.

Reset
REQ-023 On Reset_N=0, immediately and asynchronously: PIRespValid=0, PIReqRdy=0, FIFO count=0, pointers=0, and PIRespCntl/Data/Id/Priority=0.
REQ-024 PIReqRdy SHALL rise to 1 on the first CLK edge after Reset_N deasserts.
REQ-025 Memory contents SHALL NOT be reset; reads of unwritten words return X in simulation.
REQ-026 Reset asserted mid-transaction SHALL discard all queued responses; no response is emitted for them afterwards.

Verification
REQ-027 Write 8'h80, addr BASE+0x10, data 64'h1122334455667788, BE 8'hFF, id 5 -> next cycle response: Cntl 8'h01, Data 0, Id 5; then a read of the same address returns 64'h1122334455667788.
REQ-028 Partial write BE 8'h0F, data 64'hAAAAAAAA_BBBBBBBB over the prior word -> read returns 64'h11223344_BBBBBBBB.
REQ-029 Read at BASE + 8*2^DEPTH_LOG2 -> Cntl 8'h03, Data 0; memory is unchanged. POReqCntl 8'h10 -> Cntl 8'h05.
REQ-030 PORespRdy held 0 while 3 back-to-back requests are presented -> 2 accepted, PIReqRdy=0, outputs stable; on release, responses drain in order and the 3rd request is then accepted.
REQ-031 Continuous requests with PORespRdy=1 -> one accept and one response per cycle, ids in order, no bubbles.
REQ-032 Reset_N pulsed low with 2 responses queued -> PIRespValid=0 immediately, no stale responses after release, PIReqRdy=1 one edge later.
